// File: rtl/adxl362_sampler.sv
// Autonomous Wishbone master that sequences simple_spi_top to read the ADXL362
// X/Y/Z data registers and presents them as sign-extended 16-bit samples.
module adxl362_sampler #(
  parameter logic [7:0]  SPCR_VAL   = 8'h50,
  parameter int unsigned PERIOD     = 32'd0,
  parameter int unsigned POLL_LIMIT = 32'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [1:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        ncs_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic [15:0] z_o
);

  localparam logic [1:0] ADR_SPCR = 2'd0;
  localparam logic [1:0] ADR_SPSR = 2'd1;
  localparam logic [1:0] ADR_SPDR = 2'd2;

  typedef enum logic [2:0] {
    ST_CFG     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CS_LOW  = 3'd2,
    ST_WR_BYTE = 3'd3,
    ST_POLL    = 3'd4,
    ST_RD      = 3'd5,
    ST_CS_HIGH = 3'd6
  } state_t;

  // Read-register command, start address XDATA_L, then six dummy bytes.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h0B;
      3'd1:    cmd_byte = 8'h0E;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  // The device only defines 12 bits; bit 3 of the high byte is the sign.
  function automatic logic [15:0] sext_sample(input logic [7:0] lo, input logic [7:0] hi);
    sext_sample = {{4{hi[3]}}, hi[3:0], lo};
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  idx_r, idx_s;
  logic [31:0] poll_cnt_r, poll_cnt_s;
  logic [31:0] timer_r, timer_s;
  logic [47:0] shadow_r, shadow_s;
  logic [1:0]  adr_r, adr_s;
  logic [7:0]  dat_r, dat_s;
  logic        we_r, we_s;
  logic        cyc_r, cyc_s;
  logic        ncs_r, ncs_s;
  logic        busy_r, busy_s;
  logic        valid_r, valid_s;
  logic        err_r, err_s;
  logic [15:0] x_r, x_s, y_r, y_s, z_r, z_s;

  // Next-state, bus sequencing and output-register next values.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    poll_cnt_s = poll_cnt_r;
    timer_s    = timer_r;
    shadow_s   = shadow_r;
    adr_s      = adr_r;
    dat_s      = dat_r;
    we_s       = we_r;
    cyc_s      = cyc_r;
    ncs_s      = ncs_r;
    valid_s    = 1'b0;
    err_s      = err_r;
    x_s        = x_r;
    y_s        = y_r;
    z_s        = z_r;

    // A bus state opens its cycle while cyc is low; cyc is low for one cycle after every ack.
    case (state_r)
      ST_CFG: begin
        if (!cyc_r) begin
          cyc_s = 1'b1; we_s = 1'b1; adr_s = ADR_SPCR; dat_s = SPCR_VAL;
        end else if (wb_ack_i) begin
          cyc_s = 1'b0; we_s = 1'b0; state_s = ST_IDLE;
        end else begin
          cyc_s = 1'b1;
        end
      end
      ST_IDLE: begin
        if (start_i || ((PERIOD != 32'd0) && (timer_r >= PERIOD - 32'd1))) begin
          state_s = ST_CS_LOW; ncs_s = 1'b0; err_s = 1'b0; idx_s = 3'd0; timer_s = 32'd0;
        end else if (PERIOD != 32'd0) begin
          timer_s = timer_r + 32'd1;
        end else begin
          timer_s = 32'd0;
        end
      end
      ST_CS_LOW: begin
        state_s = ST_WR_BYTE;
      end
      ST_WR_BYTE: begin
        if (!cyc_r) begin
          cyc_s = 1'b1; we_s = 1'b1; adr_s = ADR_SPDR; dat_s = cmd_byte(idx_r);
        end else if (wb_ack_i) begin
          cyc_s = 1'b0; we_s = 1'b0; poll_cnt_s = 32'd0; state_s = ST_POLL;
        end else begin
          cyc_s = 1'b1;
        end
      end
      ST_POLL: begin
        if (!cyc_r) begin
          cyc_s = 1'b1; we_s = 1'b0; adr_s = ADR_SPSR;
        end else if (wb_ack_i) begin
          cyc_s = 1'b0;
          if (!wb_dat_i[0]) begin
            state_s = ST_RD;
          end else if (poll_cnt_r + 32'd1 >= POLL_LIMIT) begin
            err_s = 1'b1; ncs_s = 1'b1; state_s = ST_IDLE;
          end else begin
            poll_cnt_s = poll_cnt_r + 32'd1;
          end
        end else begin
          cyc_s = 1'b1;
        end
      end
      ST_RD: begin
        if (!cyc_r) begin
          cyc_s = 1'b1; we_s = 1'b0; adr_s = ADR_SPDR;
        end else if (wb_ack_i) begin
          cyc_s = 1'b0;
          case (idx_r)
            3'd2:    shadow_s[7:0]   = wb_dat_i;
            3'd3:    shadow_s[15:8]  = wb_dat_i;
            3'd4:    shadow_s[23:16] = wb_dat_i;
            3'd5:    shadow_s[31:24] = wb_dat_i;
            3'd6:    shadow_s[39:32] = wb_dat_i;
            3'd7:    shadow_s[47:40] = wb_dat_i;
            default: shadow_s        = shadow_r;
          endcase
          if (idx_r == 3'd7) begin
            state_s = ST_CS_HIGH;
          end else begin
            idx_s = idx_r + 3'd1; state_s = ST_WR_BYTE;
          end
        end else begin
          cyc_s = 1'b1;
        end
      end
      ST_CS_HIGH: begin
        ncs_s   = 1'b1;
        x_s     = sext_sample(shadow_r[7:0],   shadow_r[15:8]);
        y_s     = sext_sample(shadow_r[23:16], shadow_r[31:24]);
        z_s     = sext_sample(shadow_r[39:32], shadow_r[47:40]);
        valid_s = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_CFG; cyc_s = 1'b0; ncs_s = 1'b1;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= ST_CFG;   idx_r <= 3'd0;    poll_cnt_r <= 32'd0; timer_r <= 32'd0;
      shadow_r <= 48'd0;   adr_r <= 2'd0;    dat_r <= 8'd0;       we_r <= 1'b0;
      cyc_r <= 1'b0;       ncs_r <= 1'b1;    busy_r <= 1'b1;      valid_r <= 1'b0;
      err_r <= 1'b0;       x_r <= 16'd0;     y_r <= 16'd0;        z_r <= 16'd0;
    end else begin
      state_r <= state_s;  idx_r <= idx_s;   poll_cnt_r <= poll_cnt_s; timer_r <= timer_s;
      shadow_r <= shadow_s; adr_r <= adr_s;  dat_r <= dat_s;      we_r <= we_s;
      cyc_r <= cyc_s;      ncs_r <= ncs_s;   busy_r <= busy_s;    valid_r <= valid_s;
      err_r <= err_s;      x_r <= x_s;       y_r <= y_s;          z_r <= z_s;
    end
  end

  assign wb_adr_o = adr_r;
  assign wb_dat_o = dat_r;
  assign wb_we_o  = we_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;
  assign ncs_o    = ncs_r;
  assign busy_o   = busy_r;
  assign valid_o  = valid_r;
  assign err_o    = err_r;
  assign x_o      = x_r;
  assign y_o      = y_r;
  assign z_o      = z_r;

endmodule

// File: tb/tb_adxl362_sampler.sv
// Directed bench for adxl362_sampler: two instances (timer off / timer on with a short
// poll limit) each driven by a simple_spi + ADXL362 register model.
module tb_adxl362_sampler;

  logic clk = 1'b0;
  logic [1:0] rst = 2'b00;
  logic [1:0] start = 2'b00;
  logic [1:0][1:0]  adr;
  logic [1:0][7:0]  wdat;
  logic [1:0][7:0]  rdat = '0;
  logic [1:0] we, cyc, stb, ncs, busy, valid, err;
  logic [1:0] ack = 2'b00;
  logic [1:0][15:0] xo, yo, zo;

  always #5 clk = ~clk;

  adxl362_sampler #(.SPCR_VAL(8'h50), .PERIOD(32'd0), .POLL_LIMIT(32'd255)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]),
    .wb_adr_o(adr[0]), .wb_dat_o(wdat[0]), .wb_dat_i(rdat[0]), .wb_we_o(we[0]),
    .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_ack_i(ack[0]),
    .ncs_o(ncs[0]), .busy_o(busy[0]), .valid_o(valid[0]), .err_o(err[0]),
    .x_o(xo[0]), .y_o(yo[0]), .z_o(zo[0]));

  adxl362_sampler #(.SPCR_VAL(8'h50), .PERIOD(32'd2000), .POLL_LIMIT(32'd4)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]),
    .wb_adr_o(adr[1]), .wb_dat_o(wdat[1]), .wb_dat_i(rdat[1]), .wb_we_o(we[1]),
    .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_ack_i(ack[1]),
    .ncs_o(ncs[1]), .busy_o(busy[1]), .valid_o(valid[1]), .err_o(err[1]),
    .x_o(xo[1]), .y_o(yo[1]), .z_o(zo[1]));

  // Slave model configuration (written by the test sequence)
  int ack_delay[2]  = '{0, 0};
  int busy_polls[2] = '{0, 0};
  bit stuck[2]      = '{1'b0, 1'b0};
  logic [7:0] regs[2][6];

  // Slave model state and monitors
  int cycle = 0;
  int wcnt[2] = '{0, 0};
  int poll_left[2] = '{0, 0};
  int frame_wr[2] = '{0, 0};
  int acks[2] = '{0, 0};
  int cfg_cnt[2] = '{0, 0};
  int spdr_wr[2] = '{0, 0};
  int spsr_rd[2] = '{0, 0};
  int ncs_viol[2] = '{0, 0};
  int bus_viol[2] = '{0, 0};
  int valid_cnt[2] = '{0, 0};
  int last_vt[2] = '{0, 0};
  int prev_vt[2] = '{0, 0};
  logic [7:0] resp[2] = '{8'h00, 8'h00};
  logic [7:0] cfg_dat[2] = '{8'h00, 8'h00};
  logic [7:0] spdr_log[2][8];
  logic [1:0] prev_ncs = 2'b11, prev_cyc = 2'b00, prev_ack = 2'b00, prev_rst = 2'b00;
  logic [1:0][1:0] prev_adr = '0;

  // Wishbone slave + ADXL362 frame model + protocol monitors.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    for (int g = 0; g < 2; g++) begin
      ack[g]      <= 1'b0;
      rdat[g]     <= 8'hEE;
      prev_ncs[g] <= ncs[g];
      prev_cyc[g] <= cyc[g];
      prev_ack[g] <= ack[g];
      prev_rst[g] <= rst[g];
      prev_adr[g] <= adr[g];
      if (prev_ncs[g] && !ncs[g]) frame_wr[g] <= 0;
      if (valid[g]) begin
        valid_cnt[g] <= valid_cnt[g] + 1;
        prev_vt[g]   <= last_vt[g];
        last_vt[g]   <= cycle;
      end
      if ((prev_rst[g] && prev_cyc[g] && !prev_ack[g] && (!cyc[g] || !stb[g] || adr[g] != prev_adr[g]))
          || (prev_ack[g] && cyc[g]))
        bus_viol[g] <= bus_viol[g] + 1;
      if (cyc[g] && stb[g] && !ack[g]) begin
        if (wcnt[g] >= ack_delay[g]) begin
          ack[g]  <= 1'b1;
          wcnt[g] <= 0;
          acks[g] <= acks[g] + 1;
          if (adr[g] == 2'd0 && we[g]) begin
            cfg_cnt[g] <= cfg_cnt[g] + 1;
            cfg_dat[g] <= wdat[g];
          end else if (adr[g] == 2'd2 && we[g]) begin
            if (ncs[g]) ncs_viol[g] <= ncs_viol[g] + 1;
            spdr_wr[g] <= spdr_wr[g] + 1;
            if (frame_wr[g] < 8) spdr_log[g][frame_wr[g]] <= wdat[g];
            resp[g] <= (frame_wr[g] >= 2 && frame_wr[g] < 8) ? regs[g][frame_wr[g] - 2] : 8'h00;
            frame_wr[g]  <= frame_wr[g] + 1;
            poll_left[g] <= busy_polls[g];
          end else if (adr[g] == 2'd2) begin
            if (ncs[g]) ncs_viol[g] <= ncs_viol[g] + 1;
            rdat[g] <= resp[g];
          end else if (adr[g] == 2'd1) begin
            spsr_rd[g] <= spsr_rd[g] + 1;
            if (stuck[g]) rdat[g] <= 8'h05;
            else if (poll_left[g] > 0) begin
              rdat[g] <= 8'h01;
              poll_left[g] <= poll_left[g] - 1;
            end else rdat[g] <= 8'h00;
          end
        end else begin
          wcnt[g] <= wcnt[g] + 1;
        end
      end else if (!cyc[g]) begin
        wcnt[g] <= 0;
      end
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_regs(input int g, input logic [15:0] xd, input logic [15:0] yd, input logic [15:0] zd);
    regs[g][0] = xd[7:0]; regs[g][1] = xd[15:8];
    regs[g][2] = yd[7:0]; regs[g][3] = yd[15:8];
    regs[g][4] = zd[7:0]; regs[g][5] = zd[15:8];
  endtask

  task automatic wait_idle(input int g, input int bound);
    for (int i = 0; i < bound && busy[g]; i++) @(negedge clk);
  endtask

  task automatic run_acq(input int g, input string name);
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
    wait_idle(g, 3000);
    @(negedge clk);
    check({name, "_done"}, {63'd0, busy[g]}, 64'd0);
  endtask

  function automatic logic [63:0] frame_log(input int g);
    logic [63:0] lg;
    lg = 64'd0;
    for (int k = 0; k < 8; k++) lg = {lg[55:0], spdr_log[g][k]};
    return lg;
  endfunction

  typedef struct {
    logic [15:0] xd, yd, zd;
    int          dly, polls;
    logic [15:0] ex, ey, ez;
  } vec_t;

  vec_t vecs[4];
  int   v0, s0, p0, c0;
  bit   pulsed;

  initial begin
    vecs[0] = '{16'h0123, 16'h0FFE, 16'h0800, 0, 0, 16'h0123, 16'hFFFE, 16'hF800};
    vecs[1] = '{16'h0123, 16'h0FFE, 16'h0800, 3, 5, 16'h0123, 16'hFFFE, 16'hF800};
    vecs[2] = '{16'h07FF, 16'h0000, 16'hA800, 1, 2, 16'h07FF, 16'h0000, 16'hF800};
    vecs[3] = '{16'hF7FF, 16'h0F00, 16'h7001, 2, 1, 16'h07FF, 16'hFF00, 16'h0001};
    set_regs(0, 16'h0000, 16'h0000, 16'h0000);
    set_regs(1, 16'h0123, 16'h0FFE, 16'h0800);

    // Reset state
    rst = 2'b00;
    repeat (4) @(negedge clk);
    check("rst_ctrl", {47'd0, cyc[0], stb[0], we[0], adr[0], wdat[0], ncs[0], busy[0], valid[0], err[0]},
          {47'd0, 3'b000, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    check("rst_xyz", {16'd0, xo[0], yo[0], zo[0]}, 64'd0);

    // Configuration write after release
    rst = 2'b11;
    wait_idle(0, 100);
    repeat (20) @(negedge clk);
    check("cfg_count", cfg_cnt[0], 1);
    check("cfg_data", cfg_dat[0], 8'h50);
    check("cfg_total_acks", acks[0], 1);
    check("cfg_idle", {62'd0, busy[0], ncs[0]}, 64'd1);

    // Poll timeout on dut1 (POLL_LIMIT=4), then recovery
    stuck[1] = 1'b1;
    v0 = valid_cnt[1]; s0 = spdr_wr[1]; p0 = spsr_rd[1];
    run_acq(1, "t4_abort");
    check("t4_err", {63'd0, err[1]}, 64'd1);
    check("t4_ncs", {63'd0, ncs[1]}, 64'd1);
    check("t4_polls", spsr_rd[1] - p0, 4);
    check("t4_spdr_writes", spdr_wr[1] - s0, 1);
    check("t4_no_valid", valid_cnt[1] - v0, 0);
    check("t4_x_untouched", {48'd0, xo[1]}, 64'd0);
    stuck[1] = 1'b0;
    run_acq(1, "t4_recover");
    check("t4_err_cleared", {63'd0, err[1]}, 64'd0);
    check("t4_valid", valid_cnt[1] - v0, 1);
    check("t4_xyz", {16'd0, xo[1], yo[1], zo[1]}, {16'd0, 16'h0123, 16'hFFFE, 16'hF800});

    // Table-driven acquisitions on dut0
    for (int i = 0; i < 4; i++) begin
      set_regs(0, vecs[i].xd, vecs[i].yd, vecs[i].zd);
      ack_delay[0]  = vecs[i].dly;
      busy_polls[0] = vecs[i].polls;
      v0 = valid_cnt[0]; s0 = spdr_wr[0]; p0 = spsr_rd[0];
      run_acq(0, $sformatf("v%0d", i));
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_valid", i), valid_cnt[0] - v0, 1);
      check($sformatf("v%0d_x", i), xo[0], vecs[i].ex);
      check($sformatf("v%0d_y", i), yo[0], vecs[i].ey);
      check($sformatf("v%0d_z", i), zo[0], vecs[i].ez);
      check($sformatf("v%0d_spdr_writes", i), spdr_wr[0] - s0, 8);
      check($sformatf("v%0d_cmd_bytes", i), frame_log(0), 64'h0B0E_0000_0000_0000);
      check($sformatf("v%0d_polls", i), spsr_rd[0] - p0, 8 * (vecs[i].polls + 1));
      check($sformatf("v%0d_ncs_err", i), {62'd0, ncs[0], err[0]}, 64'd2);
    end
    check("bus_protocol", bus_viol[0], 0);
    check("ncs_during_spi", ncs_viol[0], 0);

    // Reset during byte 4
    set_regs(0, vecs[0].xd, vecs[0].yd, vecs[0].zd);
    ack_delay[0] = 0; busy_polls[0] = 0;
    c0 = cfg_cnt[0];
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    for (int i = 0; i < 1000 && frame_wr[0] < 5; i++) @(negedge clk);
    check("t6_reach_byte4", {63'd0, frame_wr[0] >= 5}, 64'd1);
    rst[0] = 1'b0;
    @(negedge clk);
    check("t6_rst_ctrl", {47'd0, cyc[0], stb[0], we[0], adr[0], wdat[0], ncs[0], busy[0], valid[0], err[0]},
          {47'd0, 3'b000, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    check("t6_rst_xyz", {16'd0, xo[0], yo[0], zo[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    wait_idle(0, 100);
    repeat (5) @(negedge clk);
    check("t6_cfg_rewrite", cfg_cnt[0] - c0, 1);
    check("t6_cfg_data", cfg_dat[0], 8'h50);
    check("t6_xyz_zero", {16'd0, xo[0], yo[0], zo[0]}, 64'd0);
    run_acq(0, "t6_after");
    check("t6_xyz_after", {16'd0, xo[0], yo[0], zo[0]}, {16'd0, 16'h0123, 16'hFFFE, 16'hF800});

    // Periodic acquisition on dut1 with an ignored mid-acquisition start
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    v0 = valid_cnt[1]; s0 = spdr_wr[1];
    rst[1] = 1'b1;
    pulsed = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!pulsed && !ncs[1]) begin
        start[1] = 1'b1;
        pulsed = 1'b1;
      end else begin
        start[1] = 1'b0;
      end
    end
    start[1] = 1'b0;
    check("t5_busy_start_tried", {63'd0, pulsed}, 64'd1);
    check("t5_valid_count", valid_cnt[1] - v0, 2);
    check("t5_spdr_writes", spdr_wr[1] - s0, 16);
    check("t5_spacing", {63'd0, (last_vt[1] - prev_vt[1]) >= 2000}, 64'd1);
    check("t5_bus_protocol", bus_viol[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
